// File: rtl/tpm_pkg.sv
// Shared definitions for the TPM command-frame parser.
//   - TPM command codes and structure tags used by the parser and its consumers
//   - Frame size limits (header size, maximum commandSize)
//   - Error code and parser state encodings
//   - tag_is_valid(): structure-tag check used when TPM_TAG_CHECK_EN is defined
package tpm_pkg;

    localparam logic [31:0] TPM_CC_SELF_TEST      = 32'h0000_0143;
    localparam logic [31:0] TPM_CC_STARTUP        = 32'h0000_0144;
    localparam logic [31:0] TPM_CC_SHUTDOWN       = 32'h0000_0145;
    localparam logic [31:0] TPM_CC_GET_CAPABILITY = 32'h0000_017A;
    localparam logic [31:0] TPM_CC_GET_RANDOM     = 32'h0000_017B;

    localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
    localparam logic [15:0] TPM_ST_SESSIONS    = 16'h8002;

    localparam logic [31:0] TPM_HDR_SIZE     = 32'd10;
    localparam logic [31:0] TPM_MAX_CMD_SIZE = 32'd4096;

    // Remaining-byte counter width: holds up to TPM_MAX_CMD_SIZE-6.
    localparam int unsigned TPM_CNT_W = 13;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_SIZE_SMALL = 2'd1,
        ERR_SIZE_LARGE = 2'd2,
        ERR_BAD_TAG    = 2'd3
    } tpm_err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAG     = 3'd1,
        ST_SIZE    = 3'd2,
        ST_CC      = 3'd3,
        ST_PARAM   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_PRESENT = 3'd6,
        ST_ERROR   = 3'd7
    } tpm_state_e;

    function automatic logic tag_is_valid(input logic [15:0] tag);
        return (tag == TPM_ST_NO_SESSIONS) || (tag == TPM_ST_SESSIONS);
    endfunction

endpackage

// File: rtl/tpm_byte_shifter.sv
// Big-endian field assembler.
//   clock, reset_n : clock, async active-low reset
//   data_i         : accepted byte
//   load_i         : start a new field with data_i as its first byte
//   shift_i        : append data_i as the next (less significant) byte
//   field_o        : field value including the byte presented this cycle,
//                    so the caller can capture a completed field on its last byte
module tpm_byte_shifter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  data_i,
    input  logic        load_i,
    input  logic        shift_i,
    output logic [31:0] field_o
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {24'h00_0000, data_i};
        end else if (shift_i) begin
            acc_d = {acc_q[23:0], data_i};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign field_o = acc_d;

endmodule

// File: rtl/tpm_cmd_parser.sv
// TPM command-frame header parser.
// Frame: tag[2] commandSize[4] commandCode[4] params[commandSize-10], big-endian.
//   rx_data/rx_valid/rx_ready : byte stream in, accepted on rx_valid && rx_ready
//   tpm_cc, cmd_param, cmd_tag, cmd_size : fields of the last presented frame
//   cmd_valid / err, err_code : frame result, held until cmd_ack
// Optional: TPM_TAG_CHECK_EN rejects tags other than 0x8001/0x8002 (err_code 3)
// after draining the frame.
//
// state   | meaning
// IDLE    | waiting for tag byte 0
// TAG     | tag byte 0 taken, waiting for tag byte 1
// SIZE    | collecting 4 commandSize bytes
// CC      | collecting 4 commandCode bytes
// PARAM   | capturing the first (up to) two parameter bytes
// DRAIN   | discarding remaining parameter bytes
// PRESENT | frame presented on cmd_valid until cmd_ack
// ERROR   | frame rejected on err until cmd_ack
module tpm_cmd_parser
    import tpm_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] tpm_cc,
    output logic [15:0] cmd_param,
    output logic [15:0] cmd_tag,
    output logic [31:0] cmd_size,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    output logic        err,
    output logic [1:0]  err_code
);

    tpm_state_e           state_q;
    logic [1:0]           idx_q;
    logic [TPM_CNT_W-1:0] cnt_q;
    logic [15:0]          tag_hold_q;
    logic [31:0]          size_hold_q;
    logic [31:0]          cc_hold_q;
    logic [15:0]          param_hold_q;
    logic [31:0]          tpm_cc_q;
    logic [15:0]          cmd_param_q;
    logic [15:0]          cmd_tag_q;
    logic [31:0]          cmd_size_q;
    logic                 cmd_valid_q;
    logic                 err_q;
    tpm_err_e             err_code_q;

    logic        accept;
    logic        sh_load;
    logic        sh_shift;
    logic [31:0] sh_field;
    logic        fin;
    logic [31:0] fin_cc;
    logic [15:0] fin_param;
    logic        tag_ok;

    assign rx_ready = (state_q != ST_PRESENT) && (state_q != ST_ERROR);
    assign accept   = rx_valid && rx_ready;

    // Every multi-byte field starts with a load; DRAIN bytes leave the shifter alone.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE:                   sh_load  = accept;
            ST_TAG:                    sh_shift = accept;
            ST_SIZE, ST_CC, ST_PARAM: begin
                sh_load  = accept && (idx_q == 2'd0);
                sh_shift = accept && (idx_q != 2'd0);
            end
            default: ;
        endcase
    end

    tpm_byte_shifter u_shifter (
        .clock   (clock),
        .reset_n (reset_n),
        .data_i  (rx_data),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .field_o (sh_field)
    );

    // fin marks acceptance of the last byte of a well-sized frame
    // (counter about to reach zero).
    always_comb begin
        fin       = 1'b0;
        fin_cc    = cc_hold_q;
        fin_param = param_hold_q;
        case (state_q)
            ST_CC: begin
                fin       = accept && (idx_q == 2'd3) && (cnt_q == 13'd1);
                fin_cc    = sh_field;
                fin_param = 16'h0000;
            end
            ST_PARAM: begin
                fin       = accept && (cnt_q == 13'd1);
                fin_param = (idx_q == 2'd0) ? {8'h00, rx_data} : sh_field[15:0];
            end
            ST_DRAIN: fin = accept && (cnt_q == 13'd1);
            default: ;
        endcase
    end

`ifdef TPM_TAG_CHECK_EN
    assign tag_ok = tag_is_valid(tag_hold_q);
`else
    assign tag_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            tag_hold_q   <= '0;
            size_hold_q  <= '0;
            cc_hold_q    <= '0;
            param_hold_q <= '0;
            tpm_cc_q     <= '0;
            cmd_param_q  <= '0;
            cmd_tag_q    <= '0;
            cmd_size_q   <= '0;
            cmd_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_q <= ST_TAG;
                ST_TAG: if (accept) begin
                    tag_hold_q <= sh_field[15:0];
                    idx_q      <= '0;
                    state_q    <= ST_SIZE;
                end
                ST_SIZE: if (accept) begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        size_hold_q <= sh_field;
                        if (sh_field < TPM_HDR_SIZE) begin
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SIZE_SMALL;
                        end else if (sh_field > TPM_MAX_CMD_SIZE) begin
                            state_q    <= ST_ERROR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_SIZE_LARGE;
                        end else begin
                            cnt_q   <= sh_field[TPM_CNT_W-1:0] - 13'd6;
                            state_q <= ST_CC;
                        end
                    end
                end
                ST_CC: if (accept) begin
                    cnt_q <= cnt_q - 13'd1;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cc_hold_q <= sh_field;
                        state_q   <= ST_PARAM;
                    end
                end
                ST_PARAM: if (accept) begin
                    cnt_q <= cnt_q - 13'd1;
                    if (idx_q == 2'd0) begin
                        idx_q <= 2'd1;
                    end else begin
                        param_hold_q <= sh_field[15:0];
                        state_q      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: if (accept) cnt_q <= cnt_q - 13'd1;
                ST_PRESENT, ST_ERROR: if (cmd_ack) begin
                    state_q     <= ST_IDLE;
                    idx_q       <= '0;
                    cnt_q       <= '0;
                    cmd_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    err_code_q  <= ERR_NONE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Frame completion overrides the per-state next state above.
            if (fin) begin
                idx_q <= '0;
                cnt_q <= '0;
                if (tag_ok) begin
                    state_q     <= ST_PRESENT;
                    cmd_valid_q <= 1'b1;
                    tpm_cc_q    <= fin_cc;
                    cmd_param_q <= fin_param;
                    cmd_tag_q   <= tag_hold_q;
                    cmd_size_q  <= size_hold_q;
                end else begin
                    state_q    <= ST_ERROR;
                    err_q      <= 1'b1;
                    err_code_q <= ERR_BAD_TAG;
                end
            end
        end
    end

    assign tpm_cc    = tpm_cc_q;
    assign cmd_param = cmd_param_q;
    assign cmd_tag   = cmd_tag_q;
    assign cmd_size  = cmd_size_q;
    assign cmd_valid = cmd_valid_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_tpm_cmd_parser.sv
module tb_tpm_cmd_parser;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] tpm_cc;
    logic [15:0] cmd_param;
    logic [15:0] cmd_tag;
    logic [31:0] cmd_size;
    logic        cmd_valid;
    logic        cmd_ack = 1'b0;
    logic        err;
    logic [1:0]  err_code;

    int n_vec = 0;
    int n_err = 0;

    tpm_cmd_parser dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tpm_cc    (tpm_cc),
        .cmd_param (cmd_param),
        .cmd_tag   (cmd_tag),
        .cmd_size  (cmd_size),
        .cmd_valid (cmd_valid),
        .cmd_ack   (cmd_ack),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] f[$], input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_byte(f[i], gap);
    endtask

    task automatic ack();
        cmd_ack = 1'b1;
        @(posedge clock);
        #1;
        cmd_ack = 1'b0;
        check("ack_valid_clr", {31'd0, cmd_valid}, 32'd0);
        check("ack_err_clr", {31'd0, err}, 32'd0);
        check("ack_ready", {31'd0, rx_ready}, 32'd1);
    endtask

    logic [7:0] frm[$];

    initial begin
        repeat (3) @(posedge clock);
        #1;
        // reset values
        check("rst_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_cc", tpm_cc, 32'h0);
        check("rst_param", {16'd0, cmd_param}, 32'h0);
        check("rst_tag", {16'd0, cmd_tag}, 32'h0);
        check("rst_size", cmd_size, 32'h0);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Startup, header plus 2 param bytes
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
        send_range(frm, 0, 10, 0);
        check("su_valid_early", {31'd0, cmd_valid}, 32'd0);
        send_range(frm, 11, 11, 0);
        check("su_valid", {31'd0, cmd_valid}, 32'd1);
        check("su_cc", tpm_cc, 32'h0000_0144);
        check("su_param", {16'd0, cmd_param}, 32'h0);
        check("su_size", cmd_size, 32'd12);
        check("su_tag", {16'd0, cmd_tag}, 32'h8001);
        check("su_ready", {31'd0, rx_ready}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check("su_hold", {31'd0, cmd_valid}, 32'd1);
        ack();

        // Shutdown(STATE) with 3-cycle gaps
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h45, 8'h00, 8'h01};
        send_range(frm, 0, 11, 3);
        check("sd_valid", {31'd0, cmd_valid}, 32'd1);
        check("sd_cc", tpm_cc, 32'h0000_0145);
        check("sd_param", {16'd0, cmd_param}, 32'h0001);
        ack();

        // commandSize too small
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08};
        send_range(frm, 0, 5, 0);
        check("small_err", {31'd0, err}, 32'd1);
        check("small_code", {30'd0, err_code}, 32'd1);
        check("small_valid", {31'd0, cmd_valid}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("small_ready", {31'd0, rx_ready}, 32'd0);
        check("small_cc", tpm_cc, 32'h0000_0145);
        ack();

        // commandSize too large
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h01};
        send_range(frm, 0, 5, 1);
        check("large_err", {31'd0, err}, 32'd1);
        check("large_code", {30'd0, err_code}, 32'd2);
        check("large_param", {16'd0, cmd_param}, 32'h0001);
        ack();

        // SelfTest, 20 bytes, 8 drained
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h01, 8'h43, 8'h01, 8'hAA,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_range(frm, 0, 18, 0);
        check("st_valid_early", {31'd0, cmd_valid}, 32'd0);
        check("st_ready_drain", {31'd0, rx_ready}, 32'd1);
        send_range(frm, 19, 19, 0);
        check("st_valid", {31'd0, cmd_valid}, 32'd1);
        check("st_cc", tpm_cc, 32'h0000_0143);
        check("st_param", {16'd0, cmd_param}, 32'h01AA);
        check("st_size", cmd_size, 32'd20);
        ack();

        // one parameter byte; cmd_ack mid-frame must be ignored
        frm = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h01, 8'h7B, 8'h5A};
        send_range(frm, 0, 4, 0);
        cmd_ack = 1'b1;
        @(posedge clock);
        #1;
        cmd_ack = 1'b0;
        send_range(frm, 5, 10, 0);
        check("one_valid", {31'd0, cmd_valid}, 32'd1);
        check("one_cc", tpm_cc, 32'h0000_017B);
        check("one_param", {16'd0, cmd_param}, 32'h005A);
        check("one_tag", {16'd0, cmd_tag}, 32'h8002);
        ack();

        // header only, commandSize = 10
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h44};
        send_range(frm, 0, 9, 0);
        check("hdr_valid", {31'd0, cmd_valid}, 32'd1);
        check("hdr_param", {16'd0, cmd_param}, 32'h0000);
        check("hdr_size", cmd_size, 32'd10);
        check("hdr_both", {31'd0, cmd_valid & err}, 32'd0);
        ack();

        // maximum commandSize = 4096
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7A, 8'h12, 8'h34};
        for (int i = 0; i < 4096 - 12; i++) frm.push_back(8'(i));
        send_range(frm, 0, 4094, 0);
        check("max_valid_early", {31'd0, cmd_valid}, 32'd0);
        send_range(frm, 4095, 4095, 0);
        check("max_valid", {31'd0, cmd_valid}, 32'd1);
        check("max_size", cmd_size, 32'd4096);
        check("max_param", {16'd0, cmd_param}, 32'h1234);
        ack();

        // reset mid-frame
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
        send_range(frm, 0, 4, 0);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_cc", tpm_cc, 32'h0);
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd1);
        reset_n = 1'b1;
        frm = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
        send_range(frm, 0, 11, 0);
        check("mid_valid", {31'd0, cmd_valid}, 32'd1);
        check("mid_cc", tpm_cc, 32'h0000_0144);
        check("mid_tag", {16'd0, cmd_tag}, 32'h8001);
        ack();

        // non-standard tag
        frm = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h45, 8'h00, 8'h00};
        send_range(frm, 0, 11, 0);
`ifdef TPM_TAG_CHECK_EN
        check("tag_err", {31'd0, err}, 32'd1);
        check("tag_code", {30'd0, err_code}, 32'd3);
        check("tag_valid", {31'd0, cmd_valid}, 32'd0);
`else
        check("tag_valid", {31'd0, cmd_valid}, 32'd1);
        check("tag_tag", {16'd0, cmd_tag}, 32'h1234);
        check("tag_err", {31'd0, err}, 32'd0);
`endif
        check("tag_ready", {31'd0, rx_ready}, 32'd0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tpm_cmd_parser.md
TPM_CMD_PARSER -- requirements
Module: tpm_cmd_parser

Interface
REQ-001 SHALL: clock  input  1  single clock; all state on its rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: rx_data  input  8  command byte from host transport, big-endian frame order.
REQ-004 SHALL: rx_valid  input  1  rx_data valid; byte accepted when rx_valid && rx_ready.
REQ-005 SHALL: rx_ready  output  1  parser can accept a byte this cycle.
REQ-006 SHALL: tpm_cc  output  32  commandCode of the last completed frame; feeds the management module.
REQ-007 SHALL: cmd_param  output  16  first two parameter bytes, big-endian.
REQ-008 SHALL: cmd_tag  output  16  frame tag.
REQ-009 SHALL: cmd_size  output  32  frame commandSize.
REQ-010 SHALL: cmd_valid  output  1  complete frame presented; held until cmd_ack.
REQ-011 SHALL: cmd_ack  input  1  consumer handshake; retires cmd_valid or err.
REQ-012 SHALL: err  output  1  frame rejected; held until cmd_ack.
REQ-013 SHALL: err_code  output  2  0 none, 1 size too small, 2 size too large, 3 bad tag.

Function
REQ-014 SHALL: frame layout is tag[2], commandSize[4], commandCode[4], then commandSize-10 parameter bytes.
REQ-015 SHALL: states are IDLE, TAG, SIZE, CC, PARAM, DRAIN, PRESENT, ERROR; IDLE is the state before the first tag byte; TAG is entered after tag byte 0 is accepted.
REQ-016 SHALL: rx_ready is 1 in IDLE, TAG, SIZE, CC, PARAM and DRAIN, and 0 in PRESENT and ERROR.
REQ-017 SHALL: a 13-bit remaining-byte counter loads commandSize-6 after the last size byte and decrements on each accepted byte.
REQ-018 SHALL: on the 4th size byte, commandSize<10 -> ERROR code 1; commandSize>4096 -> ERROR code 2; tpm_cc and cmd_param stay unchanged.
REQ-019 SHALL: after the 4th CC byte, commandSize==10 -> PRESENT with cmd_param=0x0000; otherwise -> PARAM.
REQ-020 SHALL: PARAM captures up to 2 bytes; if exactly 1 parameter byte exists, cmd_param={8'h00,byte}; when the count of remaining bytes is nonzero after capture, go to DRAIN, else to PRESENT.
REQ-021 SHALL: DRAIN discards bytes until the counter reaches 0, then goes to PRESENT.
REQ-022 SHALL: tpm_cc, cmd_param, cmd_tag and cmd_size update only on entry to PRESENT; cmd_valid rises in the cycle after the last frame byte is accepted.
REQ-023 SHALL: in PRESENT or ERROR, cmd_ack returns the parser to IDLE in the next cycle; a byte is accepted no earlier than one cycle after that; cmd_ack in any other state is ignored.
REQ-024 SHALL: rx_valid gaps (rx_valid=0) in any state stall parsing without loss of state.
REQ-025 SHALL: cmd_valid and err are never asserted together.

Reset
REQ-026 SHALL: reset_n low forces IDLE, rx_ready=1, tpm_cc=0, cmd_param=0, cmd_tag=0, cmd_size=0, cmd_valid=0, err=0, err_code=0, counter=0.
REQ-027 SHALL: reset asserted mid-frame discards the partial frame; the first byte after reset release is treated as tag byte 0.

Configuration
REQ-028 SHALL: with TPM_TAG_CHECK_EN defined, a tag other than 0x8001 or 0x8002 is recorded, the frame is drained per commandSize, and the parser enters ERROR code 3 instead of PRESENT.
REQ-029 SHALL: without TPM_TAG_CHECK_EN, any tag value is accepted and err_code 3 never occurs.

Structure
REQ-030 SHALL: shared package tpm_pkg holds the TPM_CC_* command codes, TPM_ST_NO_SESSIONS=0x8001, TPM_ST_SESSIONS=0x8002, TPM_HDR_SIZE=10, TPM_MAX_CMD_SIZE=4096, the err_code values and the parser state encoding.
REQ-031 SHALL: one sub-module, tpm_byte_shifter, assembles big-endian 16/32-bit fields from accepted bytes under a load/shift enable.

Verification
REQ-032 SHALL: bytes 80 01 00 00 00 0C 00 00 01 44 00 00 -> cmd_valid=1 one cycle after the last byte, tpm_cc=0x00000144, cmd_param=0x0000, cmd_size=12; cmd_ack -> IDLE.
REQ-033 SHALL: Shutdown(STATE) 80 01 00 00 00 0C 00 00 01 45 00 01, with rx_valid gaps of 3 cycles -> tpm_cc=0x145, cmd_param=0x0001.
REQ-034 SHALL: commandSize=0x00000008 -> err=1, err_code=1, rx_ready=0 until cmd_ack; tpm_cc unchanged. commandSize=0x00001001 -> err_code=2.
REQ-035 SHALL: 20-byte SelfTest frame (CC 0x143, params 01 AA ...) -> cmd_param=0x01AA, 8 bytes drained, cmd_valid only after the 20th byte.
REQ-036 SHALL: reset_n pulsed after 5 bytes, then a full Startup frame -> only the second frame is presented.
REQ-037 SHALL: TPM_TAG_CHECK_EN defined, tag 0x1234 with size 12 -> 12 bytes consumed, err_code=3; with the macro undefined, the same stimulus -> cmd_valid=1 and cmd_tag=0x1234.
